prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 134 +++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Switch-driven program loader: assembles 8-bit words from nibble pairs into a 16x8 program memory.
// Optional running checksum on chk is enabled by defining LOADER_CHECKSUM_EN.
module prog_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_mode,
  input  logic [3:0] nib_in,
  input  logic       nib_stb,
  input  logic [3:0] adrs,
  output logic [7:0] dat_out,
  output logic [3:0] wr_ptr,
  output logic       cpu_hold,
  output logic       done,
  output logic [7:0] chk
);

  typedef enum logic [2:0] {IDLE, HI, LO, WR, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] word_q, word_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];
  logic [7:0] dat_out_q;
  logic       cpu_hold_q, done_q;
  logic       block_q, block_d;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    case (state_q)
      IDLE: begin
        if (load_mode && !block_q) begin
          state_d  = HI;
          wr_ptr_d = 4'd0;
        end
      end
      HI: begin
        if (!load_mode) begin
          state_d = IDLE;
        end else if (nib_stb) begin
          word_d[7:4] = nib_in;
          state_d     = LO;
        end
      end
      LO: begin
        if (!load_mode) begin
          state_d = IDLE;
        end else if (nib_stb) begin
          word_d[3:0] = nib_in;
          state_d     = WR;
        end
      end
      WR: begin
        mem_d[wr_ptr_q] = word_q;
        if (!load_mode) begin
          state_d = IDLE;
        end else if (wr_ptr_q == 4'd15) begin
          state_d = DONE;
        end else begin
          wr_ptr_d = wr_ptr_q + 4'd1;
          state_d  = HI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A completed load stays blocked until load_mode is seen low again.
    if (state_d == DONE) begin
      block_d = 1'b1;
    end else if (!load_mode) begin
      block_d = 1'b0;
    end else begin
      block_d = block_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= 8'h00;
      wr_ptr_q   <= 4'd0;
      dat_out_q  <= 8'h00;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      block_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      dat_out_q  <= mem_q[adrs];
      cpu_hold_q <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
      block_q    <= block_d;
      mem_q      <= mem_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE && state_d == HI) begin
      chk_d = 8'h00;
    end else if (state_q == WR) begin
      chk_d = chk_q + word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= 8'h00;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chk = chk_q;
`else
  assign chk = 8'h00;
`endif

  assign dat_out  = dat_out_q;
  assign wr_ptr   = wr_ptr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-cycle comparison against a word-level loader model
// plus directed literal checks on load, abort, mid-load reset, back-to-back strobes and read-during-write.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_mode;
  logic [3:0] nib_in;
  logic       nib_stb;
  logic [3:0] adrs;
  logic [7:0] dat_out;
  logic [3:0] wr_ptr;
  logic       cpu_hold;
  logic       done;
  logic [7:0] chk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .load_mode(load_mode),
    .nib_in   (nib_in),
    .nib_stb  (nib_stb),
    .adrs     (adrs),
    .dat_out  (dat_out),
    .wr_ptr   (wr_ptr),
    .cpu_hold (cpu_hold),
    .done     (done),
    .chk      (chk)
  );

  always #5 clk = ~clk;

  // Word-level model: tracks whether a load is active, how many nibbles of the
  // current word have arrived, and which completed word is waiting to be stored.
  logic [7:0] m_mem [16];
  logic       m_loading, m_have_hi, m_store, m_finished, m_block, m_valid;
  logic [3:0] m_hi, m_ptr;
  logic [7:0] m_word, m_sum, m_dat;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    m_dat = reset ? 8'h00 : m_mem[adrs];
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_loading = 0; m_have_hi = 0; m_store = 0; m_finished = 0; m_block = 0;
      m_hi = 0; m_ptr = 0; m_word = 0; m_sum = 0;
    end else if (m_store) begin
      m_mem[m_ptr] = m_word;
      m_sum = m_sum + m_word;
      m_store = 0;
      if (!load_mode) begin
        m_loading = 0;
      end else if (m_ptr == 4'd15) begin
        m_loading = 0;
        m_finished = 1;
        m_block = 1;
      end else begin
        m_ptr = m_ptr + 4'd1;
      end
    end else if (m_finished) begin
      m_finished = 0;
      if (!load_mode) m_block = 0;
    end else if (m_loading) begin
      if (!load_mode) begin
        m_loading = 0;
        m_have_hi = 0;
      end else if (nib_stb) begin
        if (!m_have_hi) begin
          m_hi = nib_in;
          m_have_hi = 1;
        end else begin
          m_word = {m_hi, nib_in};
          m_have_hi = 0;
          m_store = 1;
        end
      end
    end else begin
      if (!load_mode) m_block = 0;
      else if (!m_block) begin
        m_loading = 1;
        m_have_hi = 0;
        m_ptr = 0;
        m_sum = 0;
      end
    end
    m_valid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      logic [7:0] exp_chk;
`ifdef LOADER_CHECKSUM_EN
      exp_chk = m_sum;
`else
      exp_chk = 8'h00;
`endif
      checkOutput("model_dat_out", dat_out, m_dat);
      checkOutput("model_wr_ptr", {4'h0, wr_ptr}, {4'h0, m_ptr});
      checkOutput("model_cpu_hold", {7'h0, cpu_hold}, {7'h0, (m_loading | m_store | m_finished)});
      checkOutput("model_done", {7'h0, done}, {7'h0, m_finished});
      checkOutput("model_chk", chk, exp_chk);
      if (done === 1'b1) done_count++;
    end
  end

  task automatic applyStimulus(input logic lm, input logic stb, input logic [3:0] nib);
    load_mode = lm;
    nib_stb   = stb;
    nib_in    = nib;
    @(negedge clk);
  endtask

  task automatic loadWord(input logic [7:0] w);
    applyStimulus(1'b1, 1'b1, w[7:4]);
    applyStimulus(1'b1, 1'b1, w[3:0]);
    applyStimulus(1'b1, 1'b0, 4'h0);
  endtask

  task automatic readAddr(input logic [3:0] a, input logic [7:0] exp, input string name);
    adrs = a;
    @(negedge clk);
    checkOutput(name, dat_out, exp);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_mode = 1'b0; nib_in = 4'h0; nib_stb = 1'b0; adrs = 4'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Empty memory after reset, CPU not held
    for (int i = 0; i < 16; i++) begin
      readAddr(i[3:0], 8'h00, "reset_mem");
      checkOutput("reset_hold", {7'h0, cpu_hold}, 8'h00);
    end

    // Full load of 0x10..0x1F
    applyStimulus(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) loadWord(8'h10 + i[7:0]);
    checkOutput("full_done", {7'h0, done}, 8'h01);
    checkOutput("full_wr_ptr", {4'h0, wr_ptr}, 8'h0F);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("no_restart_hold", {7'h0, cpu_hold}, 8'h00);
    checkOutput("done_once", done_count[7:0], 8'h01);
    readAddr(4'd5, 8'h15, "full_read5");
    readAddr(4'd15, 8'h1F, "full_read15");
`ifdef LOADER_CHECKSUM_EN
    checkOutput("full_chk", chk, 8'h78);
`endif

    // Abort after high nibble of the third word
    applyStimulus(1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0);
    loadWord(8'hA3);
    loadWord(8'h5C);
    applyStimulus(1'b1, 1'b1, 4'h7);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("abort_wr_ptr", {4'h0, wr_ptr}, 8'h02);
    checkOutput("abort_hold", {7'h0, cpu_hold}, 8'h00);
    readAddr(4'd2, 8'h12, "abort_mem2");
    readAddr(4'd0, 8'hA3, "abort_mem0");
    readAddr(4'd1, 8'h5C, "abort_mem1");

    // Reset while in LO at wr_ptr 9
    applyStimulus(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 9; i++) loadWord(8'h30 + i[7:0]);
    applyStimulus(1'b1, 1'b1, 4'hC);
    checkOutput("midload_ptr", {4'h0, wr_ptr}, 8'h09);
    reset = 1'b1;
    nib_stb = 1'b1;
    @(negedge clk);
    checkOutput("rst_dat_out", dat_out, 8'h00);
    checkOutput("rst_wr_ptr", {4'h0, wr_ptr}, 8'h00);
    checkOutput("rst_hold", {7'h0, cpu_hold}, 8'h00);
    checkOutput("rst_done", {7'h0, done}, 8'h00);
    checkOutput("rst_chk", chk, 8'h00);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0);
    loadWord(8'h42);
    readAddr(4'd0, 8'h42, "restart_mem0");
    readAddr(4'd8, 8'h00, "restart_mem8");

    // Strobes in HI, LO, WR, HI: the WR one is dropped
    applyStimulus(1'b1, 1'b1, 4'hB);
    applyStimulus(1'b1, 1'b1, 4'h6);
    applyStimulus(1'b1, 1'b1, 4'hF);
    applyStimulus(1'b1, 1'b1, 4'hD);
    applyStimulus(1'b1, 1'b1, 4'h2);
    applyStimulus(1'b1, 1'b0, 4'h0);
    readAddr(4'd1, 8'hB6, "b2b_mem1");
    readAddr(4'd2, 8'hD2, "b2b_mem2");

    // Read of address 3 during its write
    adrs = 4'd3;
    applyStimulus(1'b1, 1'b1, 4'hE);
    applyStimulus(1'b1, 1'b1, 4'h7);
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("rdw_old", dat_out, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("rdw_new", dat_out, 8'hE7);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("partial_chk", chk, 8'h42 + 8'hB6 + 8'hD2 + 8'hE7);
`endif

    applyStimulus(1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("final_hold", {7'h0, cpu_hold}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
